// File: rtl/dma_ctrl_pkg.sv
// Shared encodings for the simple DMA controller: FSM states, transfer direction
// and the full-word byte-enable pattern.
package dma_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DEV,
        BUS,
        RD_DATA,
        NEXT,
        DONE
    } dma_state_e;

    localparam logic       DIR_RD  = 1'b1;
    localparam logic       DIR_WR  = 1'b0;
    localparam logic [1:0] WE_WORD = 2'b11;

endpackage

// File: rtl/dma_ctrl_cnt.sv
// Word address register and remaining-word down-counter for one DMA block.
// Load takes priority over step; the counter saturates at zero.
module dma_ctrl_cnt #(
    parameter int ADDR_STEP = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    input  logic [14:0] load_addr,
    input  logic [15:0] load_cnt,
    output logic [14:0] addr,
    output logic        zero
);

    // Byte step converted to words; the 15-bit add wraps 0x7FFF -> 0x0000.
    localparam logic [14:0] ADDR_INC = 15'(ADDR_STEP / 2);

    logic [14:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load) begin
            addr_d = load_addr;
            cnt_d  = load_cnt;
        end else if (step && (cnt_q != 16'd0)) begin
            addr_d = addr_q + ADDR_INC;
            cnt_d  = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr = addr_q;
    assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/simple_dma_ctrl.sv
// Block DMA between a paced peripheral and the openMSP430 DMA memory port.
// Define DMA_CTRL_ERR_EN to end a block on dma_resp and expose the sticky dma_err output.
//
// state    | meaning
// IDLE     | waiting for dma_rqst; block parameters latched on request
// WAIT_DEV | waiting for dev_ack before the next word
// BUS      | memory access presented, held until dma_ready
// RD_DATA  | read data returned by memory, handed to the device
// NEXT     | word finished; next word or end of block
// DONE     | end flag raised until dma_rqst falls
module simple_dma_ctrl
    import dma_ctrl_pkg::*;
#(
    parameter logic DMA_PRIO  = 1'b0,
    parameter int   ADDR_STEP = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dma_rqst,
    input  logic        dma_rd_wr,
    input  logic [15:0] dma_start_address,
    input  logic [15:0] dma_num_words,
    input  logic        dev_ack,
    input  logic [15:0] dev_out,
    output logic [15:0] dev_in,
    output logic        dma_ack,
    output logic        dma_end_flag,
    output logic [14:0] dma_addr,
    output logic [15:0] dma_din,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    input  logic [15:0] dma_dout,
    input  logic        dma_ready,
    input  logic        dma_resp,
`ifdef DMA_CTRL_ERR_EN
    output logic        dma_err,
`endif
    output logic        dma_priority,
    output logic        dma_wkup
);

    dma_state_e  state_q, state_d;
    logic        dir_q, dir_d;
    logic [15:0] din_q, din_d;
    logic [15:0] dev_in_q, dev_in_d;
    logic        ack_q, ack_d;
    logic        end_q, end_d;
    logic        abort_q, abort_d;
    logic        cnt_load, cnt_step, cnt_zero;
    logic [14:0] cnt_addr;
    logic        resp_err;
    logic        unused_in;

`ifdef DMA_CTRL_ERR_EN
    assign resp_err = dma_resp;
`else
    assign resp_err = 1'b0;
`endif
    assign unused_in = ^{dma_start_address[0], dma_resp};

    dma_ctrl_cnt #(
        .ADDR_STEP (ADDR_STEP)
    ) u_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (cnt_load),
        .step      (cnt_step),
        .load_addr (dma_start_address[15:1]),
        .load_cnt  (dma_num_words),
        .addr      (cnt_addr),
        .zero      (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        din_d    = din_q;
        dev_in_d = dev_in_q;
        ack_d    = 1'b0;
        abort_d  = abort_q;
        cnt_load = 1'b0;
        cnt_step = 1'b0;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (dma_rqst) begin
                    cnt_load = 1'b1;
                    dir_d    = dma_rd_wr;
                    state_d  = (dma_num_words == 16'd0) ? DONE : WAIT_DEV;
                end
            end
            WAIT_DEV: begin
                if (!dma_rqst) begin
                    state_d = IDLE;
                end else if (dev_ack) begin
                    din_d   = dev_out;
                    state_d = BUS;
                end
            end
            BUS: begin
                // A request drop here only takes effect once the access is granted.
                if (!dma_rqst) begin
                    abort_d = 1'b1;
                end
                if (dma_ready) begin
                    if (resp_err) begin
                        state_d = DONE;
                    end else if (dir_q == DIR_RD) begin
                        state_d = RD_DATA;
                    end else begin
                        ack_d    = 1'b1;
                        cnt_step = 1'b1;
                        state_d  = (abort_q || !dma_rqst) ? IDLE : NEXT;
                    end
                end
            end
            RD_DATA: begin
                dev_in_d = dma_dout;
                ack_d    = 1'b1;
                cnt_step = 1'b1;
                state_d  = (abort_q || !dma_rqst) ? IDLE : NEXT;
            end
            NEXT: begin
                state_d = cnt_zero ? DONE : WAIT_DEV;
            end
            DONE: begin
                if (!dma_rqst) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        end_d = (state_q == DONE) && dma_rqst;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            dir_q    <= DIR_WR;
            din_q    <= '0;
            dev_in_q <= '0;
            ack_q    <= 1'b0;
            end_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            din_q    <= din_d;
            dev_in_q <= dev_in_d;
            ack_q    <= ack_d;
            end_q    <= end_d;
            abort_q  <= abort_d;
        end
    end

`ifdef DMA_CTRL_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && dma_rqst) begin
            err_d = 1'b0;
        end else if ((state_q == BUS) && dma_ready && dma_resp) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign dma_err = err_q;
`endif

    assign dma_en       = (state_q == BUS);
    assign dma_we       = ((state_q == BUS) && (dir_q == DIR_WR)) ? WE_WORD : 2'b00;
    assign dma_addr     = cnt_addr;
    assign dma_din      = din_q;
    assign dev_in       = dev_in_q;
    assign dma_ack      = ack_q;
    assign dma_end_flag = end_q;
    assign dma_priority = DMA_PRIO;
    assign dma_wkup     = dma_rqst & ~end_q;

endmodule

// File: tb/tb_simple_dma_ctrl.sv
// Scoreboard bench for simple_dma_ctrl: stimulus pushes expected memory accesses and
// device acknowledges; negedge monitors pop and compare as the DUTs present them.
module tb_simple_dma_ctrl;

    typedef struct {
        logic [14:0] addr;
        logic [1:0]  we;
        logic [15:0] din;
    } gnt_t;

    typedef struct {
        logic        rd;
        logic [15:0] data;
    } ack_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dma_rqst = 1'b0;
    logic        rqst_b = 1'b0;
    logic        dma_rd_wr = 1'b0;
    logic [15:0] dma_start_address = '0;
    logic [15:0] dma_num_words = '0;
    logic        dev_ack = 1'b0;
    logic [15:0] dev_out = '0;
    logic [15:0] dma_dout = '0;
    logic        dma_ready = 1'b0;
    logic        dma_resp = 1'b0;

    logic [15:0] dev_in, dev_in_b;
    logic        dma_ack, dma_ack_b;
    logic        dma_end_flag, end_b;
    logic [14:0] dma_addr, addr_b;
    logic [15:0] dma_din, din_b;
    logic        dma_en, en_b;
    logic [1:0]  dma_we, we_b;
    logic        dma_priority, prio_b;
    logic        dma_wkup, wkup_b;
`ifdef DMA_CTRL_ERR_EN
    logic        dma_err, err_b;
`endif

    int checks = 0;
    int failures = 0;
    int stall_n = 0;
    int wait_cnt = 0;
    int err_word = 0;
    int gnt_count = 0;
    logic        pend_gnt = 1'b0;
    logic [14:0] pend_addr = '0;
    logic [15:0] mem [logic [14:0]];

    gnt_t exp_gnt[$];
    ack_t exp_ack[$];
    logic [14:0] exp_b[$];

    logic        prev_en = 1'b0, prev_gnt = 1'b0, prev_ack = 1'b0;
    logic [14:0] prev_addr = '0;
    logic [1:0]  prev_we = '0;
    logic [15:0] prev_din = '0;

    simple_dma_ctrl #(.DMA_PRIO(1'b0), .ADDR_STEP(2)) dut (
        .clk(clk), .reset_n(reset_n), .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
        .dma_start_address(dma_start_address), .dma_num_words(dma_num_words),
        .dev_ack(dev_ack), .dev_out(dev_out), .dev_in(dev_in), .dma_ack(dma_ack),
        .dma_end_flag(dma_end_flag), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_en(dma_en), .dma_we(dma_we), .dma_dout(dma_dout), .dma_ready(dma_ready),
        .dma_resp(dma_resp),
`ifdef DMA_CTRL_ERR_EN
        .dma_err(dma_err),
`endif
        .dma_priority(dma_priority), .dma_wkup(dma_wkup)
    );

    simple_dma_ctrl #(.DMA_PRIO(1'b0), .ADDR_STEP(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .dma_rqst(rqst_b), .dma_rd_wr(dma_rd_wr),
        .dma_start_address(dma_start_address), .dma_num_words(dma_num_words),
        .dev_ack(dev_ack), .dev_out(dev_out), .dev_in(dev_in_b), .dma_ack(dma_ack_b),
        .dma_end_flag(end_b), .dma_addr(addr_b), .dma_din(din_b),
        .dma_en(en_b), .dma_we(we_b), .dma_dout(16'h0000), .dma_ready(1'b1),
        .dma_resp(1'b0),
`ifdef DMA_CTRL_ERR_EN
        .dma_err(err_b),
`endif
        .dma_priority(prio_b), .dma_wkup(wkup_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Memory model: grants after stall_n wait cycles, returns read data the cycle after a grant.
    always @(posedge clk) begin
        #1;
        if (pend_gnt) begin
            dma_dout = mem.exists(pend_addr) ? mem[pend_addr] : 16'h0000;
        end
        pend_gnt = 1'b0;
        dma_resp = 1'b0;
        if (!dma_en) begin
            wait_cnt  = 0;
            dma_ready = 1'b0;
        end else if (wait_cnt >= stall_n) begin
            dma_ready = 1'b1;
            gnt_count++;
            dma_resp  = (err_word != 0) && (gnt_count == err_word);
            pend_gnt  = 1'b1;
            pend_addr = dma_addr;
        end else begin
            dma_ready = 1'b0;
            wait_cnt++;
        end
    end

    always @(negedge clk) begin
        gnt_t g;
        ack_t a;
        if (!reset_n) begin
            prev_en  = 1'b0;
            prev_gnt = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (dma_en && prev_en && !prev_gnt) begin
                chk("bus_hold_addr", 32'(dma_addr), 32'(prev_addr));
                chk("bus_hold_we", 32'(dma_we), 32'(prev_we));
                chk("bus_hold_din", 32'(dma_din), 32'(prev_din));
            end
            if (dma_en && dma_ready) begin
                if (exp_gnt.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_access addr=%h required=none", dma_addr);
                end else begin
                    g = exp_gnt.pop_front();
                    chk("gnt_addr", 32'(dma_addr), 32'(g.addr));
                    chk("gnt_we", 32'(dma_we), 32'(g.we));
                    if (g.we == 2'b11) chk("gnt_din", 32'(dma_din), 32'(g.din));
                end
            end
            if (dma_ack) begin
                chk("ack_pulse", 32'(prev_ack), 32'd0);
                if (exp_ack.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack dev_in=%h required=none", dev_in);
                end else begin
                    a = exp_ack.pop_front();
                    if (a.rd) chk("dev_in", 32'(dev_in), 32'(a.data));
                end
            end
            prev_en   = dma_en;
            prev_gnt  = dma_en && dma_ready;
            prev_ack  = dma_ack;
            prev_addr = dma_addr;
            prev_we   = dma_we;
            prev_din  = dma_din;
        end
    end

    always @(negedge clk) begin
        if (reset_n && en_b) begin
            if (exp_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_access_b addr=%h required=none", addr_b);
            end else begin
                chk("gnt_addr_b", 32'(addr_b), 32'(exp_b.pop_front()));
            end
        end
    end

    task automatic start_block(input bit use_b, input logic rd, input logic [15:0] sa,
                               input logic [15:0] n, input int stall);
        @(posedge clk);
        #1;
        dma_rd_wr         = rd;
        dma_start_address = sa;
        dma_num_words     = n;
        stall_n           = stall;
        if (use_b) rqst_b = 1'b1;
        else dma_rqst = 1'b1;
    endtask

    task automatic push_wr(input logic [14:0] a, input logic [15:0] d);
        exp_gnt.push_back('{addr: a, we: 2'b11, din: d});
        exp_ack.push_back('{rd: 1'b0, data: 16'h0000});
    endtask

    task automatic push_rd(input logic [14:0] a, input logic [15:0] d);
        exp_gnt.push_back('{addr: a, we: 2'b00, din: 16'h0000});
        exp_ack.push_back('{rd: 1'b1, data: d});
    endtask

    task automatic finish_block(input string nm, input bit use_b);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((use_b ? end_b : dma_end_flag) == 1'b1) break;
        end
        chk({nm, "_end"}, 32'(use_b ? end_b : dma_end_flag), 32'd1);
        chk({nm, "_wkup_end"}, 32'(use_b ? wkup_b : dma_wkup), 32'd0);
        @(posedge clk);
        #1;
        dma_rqst = 1'b0;
        rqst_b   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_clear"}, 32'(use_b ? end_b : dma_end_flag), 32'd0);
        chk({nm, "_gnt_left"}, 32'(use_b ? exp_b.size() : exp_gnt.size()), 32'd0);
        chk({nm, "_ack_left"}, 32'(exp_ack.size()), 32'd0);
    endtask

    task automatic wait_en(input string nm);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dma_en) break;
        end
        chk(nm, 32'(dma_en), 32'd1);
    endtask

    task automatic wait_ack(input string nm);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dma_ack) break;
        end
        chk(nm, 32'(dma_ack), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[15'h0180] = 16'h1234;
        mem[15'h0181] = 16'h5678;
        #1;
        chk("rst_en", 32'(dma_en), 32'd0);
        chk("rst_ack", 32'(dma_ack), 32'd0);
        chk("rst_end", 32'(dma_end_flag), 32'd0);
        chk("rst_addr", 32'(dma_addr), 32'd0);
        chk("rst_we", 32'(dma_we), 32'd0);
        chk("rst_din", 32'(dma_din), 32'd0);
        chk("rst_dev_in", 32'(dev_in), 32'd0);
        chk("rst_wkup", 32'(dma_wkup), 32'd0);
        chk("rst_prio", 32'(dma_priority), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // write 3 words from 0x0200, device always ready, no bus stall
        dev_ack = 1'b1;
        dev_out = 16'hA5A5;
        push_wr(15'h0100, 16'hA5A5);
        push_wr(15'h0101, 16'hA5A5);
        push_wr(15'h0102, 16'hA5A5);
        start_block(1'b0, 1'b0, 16'h0200, 16'd3, 0);
        finish_block("wr3", 1'b0);

        // read 2 words from 0x0300 with a 3-cycle bus stall per word
        push_rd(15'h0180, 16'h1234);
        push_rd(15'h0181, 16'h5678);
        start_block(1'b0, 1'b1, 16'h0300, 16'd2, 3);
        finish_block("rd2", 1'b0);

        // zero-length block: end flag two cycles after the request, no access
        start_block(1'b0, 1'b0, 16'h0400, 16'd0, 0);
        @(negedge clk);
        chk("zero_flag_c0", 32'(dma_end_flag), 32'd0);
        @(negedge clk);
        chk("zero_flag_c1", 32'(dma_end_flag), 32'd0);
        chk("zero_wkup_c1", 32'(dma_wkup), 32'd1);
        @(negedge clk);
        chk("zero_flag_c2", 32'(dma_end_flag), 32'd1);
        chk("zero_wkup_c2", 32'(dma_wkup), 32'd0);
        @(posedge clk);
        #1;
        dma_rqst = 1'b0;
        @(negedge clk);
        chk("zero_flag_hold", 32'(dma_end_flag), 32'd1);
        @(negedge clk);
        chk("zero_flag_clear", 32'(dma_end_flag), 32'd0);
        chk("dev_in_hold", 32'(dev_in), 32'h5678);

        // address wrap with ADDR_STEP=2, then fixed address with ADDR_STEP=0
        dev_out = 16'h4444;
        push_wr(15'h7FFF, 16'h4444);
        push_wr(15'h0000, 16'h4444);
        start_block(1'b0, 1'b0, 16'hFFFE, 16'd2, 0);
        finish_block("wrap", 1'b0);
        exp_b.push_back(15'h7FFF);
        exp_b.push_back(15'h7FFF);
        start_block(1'b1, 1'b0, 16'hFFFE, 16'd2, 0);
        finish_block("fixed", 1'b1);

        // device holds off for 10 cycles before each word
        dev_ack = 1'b0;
        dev_out = 16'h0F0F;
        push_wr(15'h0200, 16'h0F0F);
        push_wr(15'h0201, 16'h0F0F);
        start_block(1'b0, 1'b0, 16'h0400, 16'd2, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_en_wait1", 32'(dma_en), 32'd0);
        end
        @(posedge clk);
        #1;
        dev_ack = 1'b1;
        wait_ack("pace_ack1");
        @(posedge clk);
        #1;
        dev_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_en_wait2", 32'(dma_en), 32'd0);
        end
        @(posedge clk);
        #1;
        dev_ack = 1'b1;
        finish_block("paced", 1'b0);

        // request dropped while the bus is stalled: access completes, no end flag
        push_wr(15'h0280, 16'h0F0F);
        start_block(1'b0, 1'b0, 16'h0500, 16'd3, 5);
        wait_en("abort_en_seen");
        @(posedge clk);
        #1;
        dma_rqst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("abort_no_flag", 32'(dma_end_flag), 32'd0);
        end
        chk("abort_en_off", 32'(dma_en), 32'd0);
        chk("abort_gnt_left", 32'(exp_gnt.size()), 32'd0);
        chk("abort_ack_left", 32'(exp_ack.size()), 32'd0);

`ifdef DMA_CTRL_ERR_EN
        // error response on word 2 of 4 ends the block without acknowledging it
        gnt_count = 0;
        err_word  = 2;
        exp_gnt.push_back('{addr: 15'h0300, we: 2'b11, din: 16'h0F0F});
        exp_gnt.push_back('{addr: 15'h0301, we: 2'b11, din: 16'h0F0F});
        exp_ack.push_back('{rd: 1'b0, data: 16'h0000});
        start_block(1'b0, 1'b0, 16'h0600, 16'd4, 0);
        finish_block("err", 1'b0);
        chk("err_sticky", 32'(dma_err), 32'd1);
        err_word = 0;
        start_block(1'b0, 1'b0, 16'h0000, 16'd0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("err_cleared", 32'(dma_err), 32'd0);
        finish_block("err_next", 1'b0);
`endif

        // reset in the middle of a stalled access
        start_block(1'b0, 1'b0, 16'h0700, 16'd3, 10);
        wait_en("rst_mid_en_seen");
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        dma_rqst = 1'b0;
        #1;
        chk("rst_mid_en", 32'(dma_en), 32'd0);
        chk("rst_mid_addr", 32'(dma_addr), 32'd0);
        chk("rst_mid_we", 32'(dma_we), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_idle", 32'(dma_en), 32'd0);
        chk("rst_mid_flag", 32'(dma_end_flag), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
